// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and default widths for the SRAM port arbiter.
package sram_arb_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, SLEEP, WAKE} arb_state_e;
  localparam int NUM_PORTS   = 2;
  localparam int SRAM_ADDR_W = 10;
  localparam int SRAM_DATA_W = 32;
endpackage

// File: rtl/sram_port_arbiter_rr.sv
// rr_arbiter2: two-way round-robin grant; the pointer favours the port not granted last.
module rr_arbiter2
  import sram_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] i_valid,
  input  logic                 i_en,
  output logic                 o_gnt,
  output logic                 o_idx
);
  logic r_ptr;
  assign o_idx = i_valid[1] & (~i_valid[0] | r_ptr);
  assign o_gnt = i_en & (|i_valid);
  always_ff @(posedge clk) begin
    if (rst) r_ptr <= 1'b0;
    else if (o_gnt) r_ptr <= ~o_idx;
  end
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares a single-port SRAM macro between core and vector ports,
// with round-robin grants, one-cycle read return and retention sequencing.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int         ADDR_W  = SRAM_ADDR_W,
  parameter int         DATA_W  = SRAM_DATA_W,
  parameter logic [2:0] EMA_VAL = 3'b000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          req_valid,
  output logic [NUM_PORTS-1:0]          req_ready,
  input  logic [NUM_PORTS-1:0]          req_we,
  input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
  output logic [NUM_PORTS-1:0]          resp_valid,
  output logic [DATA_W-1:0]             resp_rdata,
  input  logic                          sleep_req,
  output logic                          sleep_ack,
  output logic                          sram_cen,
  output logic                          sram_wen,
  output logic [ADDR_W-1:0]             sram_addr,
  output logic [DATA_W-1:0]             sram_d,
  input  logic [DATA_W-1:0]             sram_q,
  output logic [2:0]                    sram_ema,
  output logic                          sram_retn
);
  arb_state_e r_state;
  logic       r_rd_pend;
  logic       r_rd_id;
  logic       w_en;
  logic       w_gnt;
  logic       w_idx;
  logic       w_resp;
  logic       w_sleep;

  // Grants only in RUN with no sleep request, so sleep wins over pending valids.
  assign w_en = ~rst & (r_state == RUN) & ~sleep_req;

  rr_arbiter2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .i_valid (req_valid),
    .i_en    (w_en),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx)
  );

  assign req_ready = w_gnt ? (w_idx ? 2'b10 : 2'b01) : 2'b00;
  assign sram_cen  = ~w_gnt;
  assign sram_wen  = ~(w_gnt & req_we[w_idx]);
  assign sram_addr = ~w_gnt ? '0 : w_idx ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
  assign sram_d    = ~w_gnt ? '0 : w_idx ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
  assign sram_ema  = EMA_VAL;

  // Responses are masked during reset so a pending read is dropped immediately.
  assign w_resp     = r_rd_pend & ~rst;
  assign resp_valid = ~w_resp ? 2'b00 : r_rd_id ? 2'b10 : 2'b01;
  assign resp_rdata = w_resp ? sram_q : '0;
  assign w_sleep    = (r_state == SLEEP) & ~rst;
  assign sleep_ack  = w_sleep;
  assign sram_retn  = ~w_sleep;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RUN;
      r_rd_pend <= 1'b0;
      r_rd_id   <= 1'b0;
    end else begin
      r_rd_pend <= w_gnt & ~req_we[w_idx];
      r_rd_id   <= w_idx;
      case (r_state)
        RUN:     r_state <= sleep_req ? DRAIN : RUN;
        DRAIN:   r_state <= SLEEP;
        SLEEP:   r_state <= sleep_req ? SLEEP : WAKE;
        default: r_state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: table-driven check of grants, responses, sleep sequencing and reset.
module tb_sram_port_arbiter;
  logic        clk = 0;
  logic        rst = 1;
  logic [1:0]  req_valid = 0, req_ready, req_we = 0, resp_valid;
  logic [19:0] req_addr = 0;
  logic [63:0] req_wdata = 0;
  logic [31:0] resp_rdata, sram_d, sram_q;
  logic        sleep_req = 0, sleep_ack, sram_cen, sram_wen, sram_retn;
  logic [9:0]  sram_addr;
  logic [2:0]  sram_ema;
  logic [31:0] mem [0:1023];
  int          tests = 0, fails = 0;

  always #5 clk = ~clk;

  sram_port_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .sleep_req(sleep_req), .sleep_ack(sleep_ack), .sram_cen(sram_cen), .sram_wen(sram_wen),
    .sram_addr(sram_addr), .sram_d(sram_d), .sram_q(sram_q), .sram_ema(sram_ema), .sram_retn(sram_retn)
  );

  // Behavioural macro: write stores, read returns data on the following cycle.
  always_ff @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_wen) mem[sram_addr] <= sram_d;
      else sram_q <= mem[sram_addr];
    end
  end

  typedef struct {
    string       name;
    logic        rst, sl;
    logic [1:0]  v, we;
    logic [9:0]  a0, a1;
    logic [31:0] d0, d1;
    logic [1:0]  rdy, rv;
    logic [31:0] rd;
    logic        cen, wen;
    logic [9:0]  addr;
    logic        retn, ack;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic r, logic s, logic [1:0] v, logic [1:0] we,
                              logic [9:0] a0, logic [9:0] a1, logic [31:0] d0, logic [31:0] d1,
                              logic [1:0] rdy, logic [1:0] rv, logic [31:0] rd, logic cen,
                              logic wen, logic [9:0] addr, logic retn, logic ack);
    vec_t t;
    t.name = n; t.rst = r; t.sl = s; t.v = v; t.we = we; t.a0 = a0; t.a1 = a1;
    t.d0 = d0; t.d1 = d1; t.rdy = rdy; t.rv = rv; t.rd = rd; t.cen = cen; t.wen = wen;
    t.addr = addr; t.retn = retn; t.ack = ack;
    return t;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  localparam logic [31:0] A = 32'h1111_1111, B = 32'h2222_2222, D = 32'hDEAD_BEEF;

  initial begin
    int n;
    vecs.push_back(mk("reset",      1,0,2'b11,2'b00,10'h1,10'h2,0,0, 2'b00,2'b00,0,1,1,10'h0,1,0));
    vecs.push_back(mk("p0_wr",      0,0,2'b01,2'b01,10'hF,10'h0,32'hF,0, 2'b01,2'b00,0,0,0,10'hF,1,0));
    vecs.push_back(mk("p0_rd",      0,0,2'b01,2'b00,10'hF,10'h0,0,0, 2'b01,2'b00,0,0,1,10'hF,1,0));
    vecs.push_back(mk("rsp_F",      0,0,2'b00,2'b00,0,0,0,0, 2'b00,2'b01,32'hF,1,1,10'h0,1,0));
    vecs.push_back(mk("wr_p1",      0,0,2'b11,2'b11,10'h1,10'h2,A,B, 2'b10,2'b00,0,0,0,10'h2,1,0));
    vecs.push_back(mk("wr_p0",      0,0,2'b11,2'b11,10'h1,10'h2,A,B, 2'b01,2'b00,0,0,0,10'h1,1,0));
    vecs.push_back(mk("p1a",        0,0,2'b10,2'b00,10'h0,10'h2,0,0, 2'b10,2'b00,0,0,1,10'h2,1,0));
    vecs.push_back(mk("p1b",        0,0,2'b10,2'b00,10'h0,10'h2,0,0, 2'b10,2'b10,B,0,1,10'h2,1,0));
    vecs.push_back(mk("p1c",        0,0,2'b10,2'b00,10'h0,10'h2,0,0, 2'b10,2'b10,B,0,1,10'h2,1,0));
    vecs.push_back(mk("ptr0",       0,0,2'b11,2'b00,10'h1,10'h2,0,0, 2'b01,2'b10,B,0,1,10'h1,1,0));
    vecs.push_back(mk("slp_run",    0,1,2'b11,2'b00,10'h1,10'h2,0,0, 2'b00,2'b01,A,1,1,10'h0,1,0));
    vecs.push_back(mk("drain",      0,1,2'b11,2'b00,10'h1,10'h2,0,0, 2'b00,2'b00,0,1,1,10'h0,1,0));
    vecs.push_back(mk("sleep",      0,1,2'b11,2'b00,10'h1,10'h2,0,0, 2'b00,2'b00,0,1,1,10'h0,0,1));
    vecs.push_back(mk("sleep_fall", 0,0,2'b11,2'b00,10'h1,10'h2,0,0, 2'b00,2'b00,0,1,1,10'h0,0,1));
    vecs.push_back(mk("wake",       0,0,2'b11,2'b00,10'h1,10'h2,0,0, 2'b00,2'b00,0,1,1,10'h0,1,0));
    vecs.push_back(mk("resume",     0,0,2'b11,2'b00,10'h1,10'h2,0,0, 2'b10,2'b00,0,0,1,10'h2,1,0));
    vecs.push_back(mk("rd_p0",      0,0,2'b01,2'b00,10'h1,10'h2,0,0, 2'b01,2'b10,B,0,1,10'h1,1,0));
    vecs.push_back(mk("rsp_p0",     0,0,2'b00,2'b00,0,0,0,0, 2'b00,2'b01,A,1,1,10'h0,1,0));
    vecs.push_back(mk("slp2",       0,1,2'b00,2'b00,0,0,0,0, 2'b00,2'b00,0,1,1,10'h0,1,0));
    vecs.push_back(mk("drain2",     0,0,2'b00,2'b00,0,0,0,0, 2'b00,2'b00,0,1,1,10'h0,1,0));
    vecs.push_back(mk("sleep2",     0,0,2'b00,2'b00,0,0,0,0, 2'b00,2'b00,0,1,1,10'h0,0,1));
    vecs.push_back(mk("wake2",      0,0,2'b01,2'b00,10'hF,0,0,0, 2'b00,2'b00,0,1,1,10'h0,1,0));
    vecs.push_back(mk("rd_pre_rst", 0,0,2'b01,2'b00,10'hF,0,0,0, 2'b01,2'b00,0,0,1,10'hF,1,0));
    vecs.push_back(mk("rst_mid",    1,0,2'b11,2'b00,10'h1,10'h2,0,0, 2'b00,2'b00,0,1,1,10'h0,1,0));
    vecs.push_back(mk("rr0",        0,0,2'b11,2'b00,10'h1,10'h2,0,0, 2'b01,2'b00,0,0,1,10'h1,1,0));
    vecs.push_back(mk("rr1",        0,0,2'b11,2'b00,10'h1,10'h2,0,0, 2'b10,2'b01,A,0,1,10'h2,1,0));
    vecs.push_back(mk("rr2",        0,0,2'b11,2'b00,10'h1,10'h2,0,0, 2'b01,2'b10,B,0,1,10'h1,1,0));
    vecs.push_back(mk("rr3",        0,0,2'b11,2'b00,10'h1,10'h2,0,0, 2'b10,2'b01,A,0,1,10'h2,1,0));
    vecs.push_back(mk("rr_end",     0,0,2'b00,2'b00,0,0,0,0, 2'b00,2'b10,B,1,1,10'h0,1,0));
    vecs.push_back(mk("p1_wr3ff",   0,0,2'b10,2'b10,10'h0,10'h3FF,0,D, 2'b10,2'b00,0,0,0,10'h3FF,1,0));
    vecs.push_back(mk("p0_rd3ff",   0,0,2'b01,2'b00,10'h3FF,10'h0,0,0, 2'b01,2'b00,0,0,1,10'h3FF,1,0));
    vecs.push_back(mk("rsp_3ff",    0,0,2'b00,2'b00,0,0,0,0, 2'b00,2'b01,D,1,1,10'h0,1,0));

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      rst = vecs[i].rst; sleep_req = vecs[i].sl; req_valid = vecs[i].v; req_we = vecs[i].we;
      req_addr = {vecs[i].a1, vecs[i].a0}; req_wdata = {vecs[i].d1, vecs[i].d0};
      @(negedge clk);
      chk({vecs[i].name, ".ready"},  {30'd0, req_ready},  {30'd0, vecs[i].rdy});
      chk({vecs[i].name, ".rvalid"}, {30'd0, resp_valid}, {30'd0, vecs[i].rv});
      chk({vecs[i].name, ".rdata"},  resp_rdata,          vecs[i].rd);
      chk({vecs[i].name, ".cen"},    {31'd0, sram_cen},   {31'd0, vecs[i].cen});
      chk({vecs[i].name, ".wen"},    {31'd0, sram_wen},   {31'd0, vecs[i].wen});
      chk({vecs[i].name, ".addr"},   {22'd0, sram_addr},  {22'd0, vecs[i].addr});
      chk({vecs[i].name, ".retn"},   {31'd0, sram_retn},  {31'd0, vecs[i].retn});
      chk({vecs[i].name, ".ack"},    {31'd0, sleep_ack},  {31'd0, vecs[i].ack});
    end
    chk("ema", {29'd0, sram_ema}, 32'd0);

    // Sleep entry latency with a bounded wait, then wake with a request held.
    @(posedge clk); #1;
    sleep_req = 1; req_valid = 2'b01; req_we = 0; req_addr = {10'h0, 10'h3FF};
    @(negedge clk);
    n = 0;
    while (!sleep_ack && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("sleep_latency", n, 2);
    chk("sleep_retn", {31'd0, sram_retn}, 0);
    chk("sleep_ready", {30'd0, req_ready}, 0);
    @(posedge clk); #1;
    sleep_req = 0;
    @(negedge clk);
    chk("still_sleep_ack", {31'd0, sleep_ack}, 1);
    @(negedge clk);
    chk("wake_ack", {31'd0, sleep_ack}, 0);
    chk("wake_retn", {31'd0, sram_retn}, 1);
    chk("wake_ready", {30'd0, req_ready}, 0);
    @(negedge clk);
    chk("run_ready", {30'd0, req_ready}, 2'b01);
    @(posedge clk); #1;
    req_valid = 0;
    @(negedge clk);
    chk("run_rdata", resp_rdata, D);
    chk("run_rvalid", {30'd0, resp_valid}, 2'b01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
